// File: rtl/ws_flush_ctrl.sv
// Pipeline flush / refetch controller: flushes on WB events, drains stale fetches, then redirects.
// Optional TLB_REFILL_VEC_EN: exceptions flagged as TLB refill vector to REFILL_VEC.
module ws_flush_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 2,
  parameter logic [31:0] EXC_VEC         = 32'hbfc00380,
  parameter logic [31:0] REFILL_VEC      = 32'hbfc00200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_exc,
  input  logic        ws_exc_refill,
  input  logic        ws_eret,
  input  logic        ws_refetch,
  input  logic [31:0] ws_epc,
  input  logic [31:0] ws_refetch_pc,
  input  logic        inst_req_hs,
  input  logic        inst_data_ok,
  output logic        flush,
  output logic        fs_stall,
  output logic        inst_discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        fs_redirect_ready
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDrain    = 2'd1;
  localparam logic [1:0] StRedirect = 2'd2;

  localparam logic [CNT_W:0] MaxOut = (CNT_W + 1)'(MAX_OUTSTANDING);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [31:0]      pc_q, pc_d;

  logic             any_event;
  logic [31:0]      exc_target;
  logic [31:0]      target;
  logic [CNT_W:0]   out_inc;
  logic [CNT_W:0]   out_nxt;

`ifdef TLB_REFILL_VEC_EN
  assign exc_target = ws_exc_refill ? REFILL_VEC : EXC_VEC;
`else
  logic [32:0] unused_cfg;
  assign unused_cfg = {ws_exc_refill, REFILL_VEC};
  assign exc_target = EXC_VEC;
`endif

  assign any_event = ws_exc | ws_eret | ws_refetch;

  always_comb begin
    target = ws_refetch_pc;
    if (ws_exc) begin
      target = exc_target;
    end else if (ws_eret) begin
      target = ws_epc;
    end
  end

  // Outstanding count tracks the bus in every state; underflow saturates at zero.
  assign out_inc = {1'b0, out_q} + {{CNT_W{1'b0}}, inst_req_hs};

  always_comb begin
    out_nxt = out_inc;
    if (inst_data_ok && (out_inc != '0)) begin
      out_nxt = out_inc - 1'b1;
    end
    if (out_nxt > MaxOut) begin
      out_nxt = MaxOut;
    end
  end

  assign out_d = out_nxt[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    pc_d    = pc_q;
    case (state_q)
      StIdle: begin
        if (any_event) begin
          pc_d    = target;
          // Same-cycle request/data_ok are folded in exactly once via out_d.
          disc_d  = out_d;
          state_d = (out_d != '0) ? StDrain : StRedirect;
        end
      end
      StDrain: begin
        if (inst_data_ok && (disc_q != '0)) begin
          disc_d = disc_q - CNT_W'(1);
        end
        if (disc_d == '0) begin
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        if (fs_redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      out_q   <= '0;
      disc_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      pc_q    <= pc_d;
    end
  end

  assign flush          = (state_q == StIdle) && any_event;
  assign fs_stall       = (state_q != StIdle);
  assign redirect_valid = (state_q == StRedirect);
  assign redirect_pc    = pc_q;
  assign inst_discard   = inst_data_ok && ((state_q == StDrain) || flush);

endmodule

// File: tb/tb_ws_flush_ctrl.sv
// Directed table-driven bench for ws_flush_ctrl; one row per clock cycle.
module tb_ws_flush_ctrl;

  localparam logic [31:0] P380 = 32'hbfc00380;
  localparam logic [31:0] PE   = 32'h80001234;
  localparam logic [31:0] PR   = 32'hbfc00104;
`ifdef TLB_REFILL_VEC_EN
  localparam logic [31:0] PS   = 32'hbfc00200;
`else
  localparam logic [31:0] PS   = 32'hbfc00380;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_exc, ws_exc_refill, ws_eret, ws_refetch;
  logic [31:0] ws_epc, ws_refetch_pc;
  logic        inst_req_hs, inst_data_ok;
  logic        flush, fs_stall, inst_discard, redirect_valid;
  logic [31:0] redirect_pc;
  logic        fs_redirect_ready;

  // Input bits: {reset, exc, refill, eret, refetch, req_hs, data_ok, ready}
  // Expected bits: {flush, fs_stall, inst_discard, redirect_valid}
  typedef struct {
    logic [7:0]  in;
    logic [3:0]  exp;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  ws_flush_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .ws_exc            (ws_exc),
    .ws_exc_refill     (ws_exc_refill),
    .ws_eret           (ws_eret),
    .ws_refetch        (ws_refetch),
    .ws_epc            (ws_epc),
    .ws_refetch_pc     (ws_refetch_pc),
    .inst_req_hs       (inst_req_hs),
    .inst_data_ok      (inst_data_ok),
    .flush             (flush),
    .fs_stall          (fs_stall),
    .inst_discard      (inst_discard),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .fs_redirect_ready (fs_redirect_ready)
  );

  always #5 clk = ~clk;

  function automatic void add(logic [7:0] in, logic [3:0] exp, logic [31:0] exp_pc);
    vec_t v;
    v.in     = in;
    v.exp    = exp;
    v.exp_pc = exp_pc;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(logic [7:0] in);
    {reset, ws_exc, ws_exc_refill, ws_eret, ws_refetch,
     inst_req_hs, inst_data_ok, fs_redirect_ready} = in;
  endtask

  initial begin
    // Exception, no outstanding requests
    add(8'b0000_0000, 4'b0000, 32'h0);
    add(8'b0100_0001, 4'b1000, 32'h0);
    add(8'b0000_0001, 4'b0101, P380);
    add(8'b0000_0000, 4'b0000, P380);
    // ERET with two outstanding requests, data returns at T+3 and T+5
    add(8'b0000_0100, 4'b0000, P380);
    add(8'b0000_0100, 4'b0000, P380);
    add(8'b0001_0000, 4'b1000, P380);
    add(8'b0000_0000, 4'b0100, PE);
    add(8'b0000_0000, 4'b0100, PE);
    add(8'b0000_0010, 4'b0110, PE);
    add(8'b0000_0000, 4'b0100, PE);
    add(8'b0000_0010, 4'b0110, PE);
    add(8'b0000_0001, 4'b0101, PE);
    add(8'b0000_0000, 4'b0000, PE);
    // Idle data_ok is not discarded; then refetch with req+data_ok in the event cycle
    add(8'b0000_0100, 4'b0000, PE);
    add(8'b0000_0010, 4'b0000, PE);
    add(8'b0000_0100, 4'b0000, PE);
    add(8'b0000_1110, 4'b1010, PE);
    add(8'b0000_0000, 4'b0100, PR);
    add(8'b0000_0010, 4'b0110, PR);
    add(8'b0000_0001, 4'b0101, PR);
    add(8'b0000_0000, 4'b0000, PR);
    // Simultaneous exc + refill + eret
    add(8'b0111_0001, 4'b1000, PR);
    add(8'b0000_0001, 4'b0101, PS);
    add(8'b0000_0000, 4'b0000, PS);
    // Ready held low; events during the wait are ignored
    add(8'b0100_0000, 4'b1000, PS);
    add(8'b0000_0000, 4'b0101, P380);
    add(8'b0100_0000, 4'b0101, P380);
    add(8'b0001_0000, 4'b0101, P380);
    add(8'b0000_0000, 4'b0101, P380);
    add(8'b0000_0001, 4'b0101, P380);
    add(8'b0000_0000, 4'b0000, P380);
    // Reset while draining, then confirm the outstanding count was cleared
    add(8'b0000_0100, 4'b0000, P380);
    add(8'b0100_0000, 4'b1000, P380);
    add(8'b0000_0000, 4'b0100, P380);
    add(8'b1000_0000, 4'b0100, P380);
    add(8'b0000_0000, 4'b0000, 32'h0);
    add(8'b0100_0000, 4'b1000, 32'h0);
    add(8'b0000_0001, 4'b0101, P380);
    add(8'b0000_0000, 4'b0000, P380);

    ws_epc        = PE;
    ws_refetch_pc = PR;
    drive(8'b1000_0000);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].in);
      @(negedge clk);
      chk("flush",          i, {31'b0, flush},          {31'b0, vecs[i].exp[3]});
      chk("fs_stall",       i, {31'b0, fs_stall},       {31'b0, vecs[i].exp[2]});
      chk("inst_discard",   i, {31'b0, inst_discard},   {31'b0, vecs[i].exp[1]});
      chk("redirect_valid", i, {31'b0, redirect_valid}, {31'b0, vecs[i].exp[0]});
      chk("redirect_pc",    i, redirect_pc,             vecs[i].exp_pc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws_flush_ctrl.md
# ws_flush_ctrl

Pipeline flush and refetch controller for the 5-stage MIPS core. It takes exception, ERET and TLB-refetch events from the writeback stage and issues a one-cycle pipeline flush. It then drains instruction-bus requests already issued before the flush, discarding their returning data, and hands a redirect PC to the fetch stage through a valid/ready handshake.

## Interface
Parameters:
- MAX_OUTSTANDING, 2: maximum in-flight instruction-bus requests.
- CNT_W, 2: outstanding/discard counter width; must hold MAX_OUTSTANDING.
- EXC_VEC, 32'hbfc00380: general exception entry.
- REFILL_VEC, 32'hbfc00200: TLB-refill entry, used only with the configuration macro.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- ws_exc  in  1  WB exception; already qualified with ws_valid.
- ws_exc_refill  in  1  the exception is a TLB refill with Status.EXL=0.
- ws_eret  in  1  WB ERET; already qualified.
- ws_refetch  in  1  WB TLBWI/TLBR; the following instruction must be refetched.
- ws_epc  in  32  CP0 EPC, the ERET target.
- ws_refetch_pc  in  32  refetch target.
- inst_req_hs  in  1  instruction request accepted (req && addr_ok).
- inst_data_ok  in  1  instruction data returned.
- flush  out  1  flushes the FS, DS, ES, MS and WS valids.
- fs_stall  out  1  FS must not issue requests.
- inst_discard  out  1  the current inst_data_ok belongs to a stale request.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  next fetch PC.
- fs_redirect_ready  in  1  FS accepts the redirect.

## Operation
- Event priority: ws_exc > ws_eret > ws_refetch.
- Target selection:
  - Exception: EXC_VEC, or REFILL_VEC when ws_exc_refill is set (see Configuration).
  - ERET: ws_epc.
  - Refetch: ws_refetch_pc.
- Outstanding counter `out`:
  - Counts +inst_req_hs and −inst_data_ok every cycle, in every state.
  - Saturates at 0 if data_ok arrives with out=0; this is a protocol error for assertions.
  - Never exceeds MAX_OUTSTANDING.
- FSM states: IDLE, DRAIN, REDIRECT.
- IDLE:
  - flush = any event, combinationally, the same cycle.
  - On an event:
    - Latch the target into redirect_pc.
    - Load disc = out + inst_req_hs − inst_data_ok.
    - Go to DRAIN if disc≠0, otherwise REDIRECT.
- DRAIN:
  - fs_stall=1.
  - Each inst_data_ok decrements disc.
  - When disc reaches 0 (including on the decrement cycle itself), go to REDIRECT next cycle.
- REDIRECT:
  - fs_stall=1, redirect_valid=1.
  - On redirect_valid && fs_redirect_ready, go to IDLE. fs_stall and redirect_valid drop the next cycle.
- inst_discard = inst_data_ok && (state==DRAIN || (state==IDLE && flush)).
- Events arriving outside IDLE are ignored and flush stays 0. The pipeline is empty in those states, so such events are assertion failures.
- redirect_pc holds its value until the next accepted event.

## Timing
- Reset values: state IDLE, out=0, disc=0, flush=0, fs_stall=0, inst_discard=0, redirect_valid=0, redirect_pc=0.
- Event in cycle T:
  - flush=1 in T only.
  - fs_stall=1 from T+1.
  - With no drain, redirect_valid=1 at T+1.
- Drain latency: redirect_valid is asserted in the cycle after the last stale data_ok.
- A request accepted in T counts as stale. A data_ok in T is stale and gets inst_discard=1.
- A request or data_ok in the same cycle as the event is folded into the disc load exactly once.
- Handshake: redirect_valid and redirect_pc are stable until ready is sampled high. fs_redirect_ready while redirect_valid=0 has no effect.
- Reset mid-operation returns every output to its reset value in the next cycle, with no partial redirect.

## Configuration
- Macro TLB_REFILL_VEC_EN.
- Defined: an exception with ws_exc_refill=1 targets REFILL_VEC.
- Undefined: ws_exc_refill is ignored and every exception targets EXC_VEC.

## Test plan
- Exception with out=0, ready=1:
  - flush=1 at T.
  - redirect_valid=1, redirect_pc=32'hbfc00380 at T+1.
  - Back in IDLE at T+2 with fs_stall=0.
- ERET with ws_epc=32'h8000_1234 and out=2:
  - Two data_ok at T+3 and T+5, both with inst_discard=1.
  - redirect_valid at T+6 with pc 32'h8000_1234.
- TLBWI refetch with ws_refetch_pc=32'hbfc0_0104, and inst_req_hs plus inst_data_ok in T with out=1:
  - disc=1.
  - The data_ok in T has inst_discard=1.
  - Redirect is issued after one further data_ok.
- Simultaneous ws_exc, ws_exc_refill, ws_eret:
  - Target 32'hbfc00200 with TLB_REFILL_VEC_EN defined.
  - Target 32'hbfc00380 without it.
- fs_redirect_ready held low for 4 cycles:
  - redirect_valid and redirect_pc stay stable.
  - A ws_exc pulse during the wait produces no flush.
- Reset asserted in DRAIN with disc=1: all outputs return to reset values at the next edge, out=0.
